ftdi_tx_arbiter: RTL and testbench
==================================

# ftdi_tx_arbiter

Shares the single FTDI transmit byte channel between `NUM_SRC` pulse-driven byte sources, such as the loop-back test generator and command-response sources. Each source presents a byte with a one-cycle strobe and cannot be stalled, so each source gets a small FIFO. A round-robin scheduler drains the FIFOs into a valid/ready output toward the FTDI TX engine. Overflow is flagged per source and never stalls the sources.

## Interface
- `NUM_SRC`, default 2: number of byte sources, range 2..8.
- `FIFO_DEPTH`, default 4: entries per source FIFO; a power of two, minimum 2.
- `clk_i` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `src_data` in `8*NUM_SRC`: byte of source i on bits [8i+7:8i].
- `src_pulse` in `NUM_SRC`: one-cycle write strobe per source.
- `src_enable` in `NUM_SRC`: 0 means strobes from that source are ignored.
- `ovf_clr` in `NUM_SRC`: clears the matching `src_ovf` bit.
- `src_ovf` out `NUM_SRC`: sticky flag, set when a byte is dropped because its FIFO is full.
- `tx_data` out 8: output byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: downstream accepts the byte; a transfer occurs when `tx_valid & tx_ready`.
- `tx_src` out `$clog2(NUM_SRC)`: index of the source that supplied the current `tx_data`.

## Operation
- **Push:** `src_pulse[i] & src_enable[i]` writes `src_data[i]` into FIFO i.
  - If FIFO i is full and not popped in the same cycle, the byte is dropped and `src_ovf[i]` is set.
  - Full with a pop in the same cycle: the push is accepted.
  - A strobe with `src_enable[i]=0` is dropped silently; `src_ovf` does not change.
  - Bytes already queued from a disabled source are still drained.
- **`src_ovf` update:** set has priority over `ovf_clr` in the same cycle.
- **Eligibility:** source i is eligible when FIFO i is non-empty at the start of the cycle. There is no push-to-pop bypass.
- **Round robin:** search starts at `last_grant+1` modulo `NUM_SRC`. The first eligible source wins. `last_grant` updates to the winner on each pop.
- **FSM states:**
  - IDLE: `tx_valid=0`. If any source is eligible, pop the winner into the output register and go to HOLD.
  - HOLD: `tx_valid=1`. `tx_data` and `tx_src` stay stable until a transfer. On a transfer with another source eligible, pop the next winner in the same cycle and stay in HOLD. On a transfer with none eligible, go to IDLE.
  - There is no transition out of HOLD without a transfer.
- **Counters:** FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Occupancy counts are `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- **Reset values:** `tx_valid=0`, `tx_data=8'd0`, `tx_src=0`, `src_ovf=0`, all FIFOs empty, `last_grant=NUM_SRC-1` so source 0 wins first, FSM in IDLE.
- **Reset mid-operation:** `rst` high for one cycle discards all queued bytes and any pending `tx_valid` on the next edge.
- **Latency:** a strobe in cycle N writes the FIFO at edge N+1. With the FSM in IDLE, `tx_valid=1` is seen in cycle N+2.
- **Throughput:** one byte per cycle while `tx_ready` is held high and data is queued.
- **Backpressure:** while `tx_ready=0`, the output holds and the FIFOs keep accepting pushes up to full.

## Structure
- **Shared package `ftdi_pkg`:** ASCII constants `ASCII_0=8'd48`, `ASCII_9=8'd57`, `ASCII_DASH=8'd45`; the FSM state enum `{ARB_IDLE, ARB_HOLD}`; byte type `byte_t` (8 bits).
- **Sub-module `byte_fifo`:** parameter `DEPTH`. Ports `push`, `din`, `pop`, `dout`, `empty`, `full`. `dout` is combinational from the read pointer. It is instantiated `NUM_SRC` times in a generate loop.
- **Top level:** the arbiter FSM, the round-robin search, the output register and the `src_ovf` logic.

## Test plan
1. **Reset:** hold `rst` 3 cycles with strobes active. Expect `tx_valid=0` and `src_ovf=0` throughout. `tx_valid` rises 2 cycles after the first strobe following reset.
2. **Ordering:** source 0 pulses 48, 45, 49 with `tx_ready=1`. Expect output 48, 45, 49 on consecutive transfers, `tx_src=0`.
3. **Simultaneous strobes:** both sources strobe in the same cycle, src0=8'h30 and src1=8'h41, then again with 8'h31 and 8'h42. Expect output order 30(0), 41(1), 31(0), 42(1).
4. **Overflow:** hold `tx_ready=0` and send 6 strobes from source 1 with `FIFO_DEPTH=4`.
   - One byte sits in the output register and 4 in the FIFO.
   - Expect `src_ovf[1]=1` after the 6th strobe.
   - Releasing `tx_ready` yields exactly the first 5 bytes.
   - Then `ovf_clr[1]` clears the flag.
5. **Backpressure:** toggle `tx_ready` randomly for 200 cycles under two-source traffic. Expect `tx_data` and `tx_src` stable while `tx_valid & !tx_ready`, with no loss or duplication against the scoreboard.
6. **Disable and reset mid-stream:**
   - `src_enable[0]=0` with strobes: nothing is queued and `src_ovf[0]` stays 0.
   - Assert `rst` with 3 bytes queued: all are discarded and `tx_valid=0` on the next cycle.

Source files
------------

// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI transmit path: byte type, ASCII constants
// used by the byte sources, and the transmit arbiter state encoding.
package ftdi_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t ASCII_0    = 8'd48;
  localparam byte_t ASCII_9    = 8'd57;
  localparam byte_t ASCII_DASH = 8'd45;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

endpackage

// File: rtl/ftdi_tx_arbiter_byte_fifo.sv
// Small synchronous byte FIFO that gives each strobe-driven source somewhere
// to park bytes while the shared transmit channel is busy. A push into a full
// FIFO is only accepted when a pop frees a slot in the same cycle.
import ftdi_pkg::*;

module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst,
  input  logic  push,
  input  byte_t din,
  input  logic  pop,
  output byte_t dout,
  output logic  empty,
  output logic  full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  byte_t         mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];

  // Advance the pointers and occupancy for this cycle's accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Shares the FTDI transmit byte channel between several strobe-driven byte
// sources. Each source feeds its own FIFO; a round-robin scheduler moves one
// byte at a time into a valid/ready output register. Sources are never
// stalled: a byte that finds its FIFO full is dropped and flagged.
import ftdi_pkg::*;

module ftdi_tx_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst,
  input  logic [8*NUM_SRC-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_pulse,
  input  logic [NUM_SRC-1:0]         src_enable,
  input  logic [NUM_SRC-1:0]         ovf_clr,
  output logic [NUM_SRC-1:0]         src_ovf,
  output byte_t                      tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_SRC)-1:0] tx_src
);

  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] push_req;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] pop_vec;
  byte_t              fifo_dout [NUM_SRC];

  arb_state_e         state_q, state_d;
  logic               tx_valid_q, tx_valid_d;
  byte_t              tx_data_q, tx_data_d;
  logic [SW-1:0]      tx_src_q, tx_src_d;
  logic [SW-1:0]      last_grant_q, last_grant_d;
  logic [NUM_SRC-1:0] src_ovf_q, src_ovf_d;

  logic               found;
  logic [SW-1:0]      winner;
  logic               do_pop;
  int                 idx;

  assign push_req = src_pulse & src_enable;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
    byte_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i(clk_i),
      .rst  (rst),
      .push (push_req[gi]),
      .din  (src_data[8*gi +: 8]),
      .pop  (pop_vec[gi]),
      .dout (fifo_dout[gi]),
      .empty(fifo_empty[gi]),
      .full (fifo_full[gi])
    );
  end

  // Round-robin search starting just after the last granted source.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_SRC;
      if (!found && !fifo_empty[SW'(idx)]) begin
        found  = 1'b1;
        winner = SW'(idx);
      end
    end
  end

  // Arbiter next state: load the output register when it is free or drained.
  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_src_d     = tx_src_q;
    last_grant_d = last_grant_q;
    pop_vec      = '0;
    do_pop       = found && ((state_q == ARB_IDLE) || tx_ready);
    if (do_pop) begin
      pop_vec[winner] = 1'b1;
      tx_data_d       = fifo_dout[winner];
      tx_src_d        = winner;
      last_grant_d    = winner;
    end
    case (state_q)
      ARB_IDLE: if (found) state_d = ARB_HOLD;
      ARB_HOLD: if (tx_ready && !found) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    tx_valid_d = (state_d == ARB_HOLD);
  end

  // Sticky overflow flags; a new drop wins over a clear in the same cycle.
  always_comb begin
    src_ovf_d = src_ovf_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_req[i] && fifo_full[i] && !pop_vec[i]) begin
        src_ovf_d[i] = 1'b1;
      end else if (ovf_clr[i]) begin
        src_ovf_d[i] = 1'b0;
      end
    end
  end

  // Arbiter state, output register and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_src_q     <= '0;
      last_grant_q <= SW'(NUM_SRC - 1);
      src_ovf_q    <= '0;
    end else begin
      state_q      <= state_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_src_q     <= tx_src_d;
      last_grant_q <= last_grant_d;
      src_ovf_q    <= src_ovf_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_src   = tx_src_q;
  assign src_ovf  = src_ovf_q;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Directed bench for the FTDI transmit arbiter with two sources and 4-deep
// FIFOs. Transfers are captured just before each clock edge and compared to
// hand-derived expectations or a per-source scoreboard.
import ftdi_pkg::*;

module tb_ftdi_tx_arbiter;

  logic        clk_i;
  logic        rst;
  logic [15:0] src_data;
  logic [1:0]  src_pulse;
  logic [1:0]  src_enable;
  logic [1:0]  ovf_clr;
  logic [1:0]  src_ovf;
  byte_t       tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [0:0]  tx_src;

  typedef struct {
    logic [0:0] src;
    byte_t      data;
  } xfer_t;

  xfer_t got[$];
  byte_t expq0[$];
  byte_t expq1[$];
  int    outstanding[2];
  int    total = 0;
  int    bad   = 0;

  ftdi_tx_arbiter #(
    .NUM_SRC   (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .src_data  (src_data),
    .src_pulse (src_pulse),
    .src_enable(src_enable),
    .ovf_clr   (ovf_clr),
    .src_ovf   (src_ovf),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_src    (tx_src)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One comparison: counts it, and reports and counts a failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record a transfer that will happen at the coming edge, then advance past it.
  task automatic step();
    if (tx_valid === 1'b1 && tx_ready === 1'b1) got.push_back('{tx_src, tx_data});
    @(posedge clk_i);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present strobes and data for exactly one cycle.
  task automatic applyStimulus(input logic [1:0] pulse, input byte_t d0, input byte_t d1);
    src_pulse = pulse;
    src_data  = {d1, d0};
    step();
    src_pulse = 2'b00;
  endtask

  task automatic checkXfer(input string tag, input int idx, input logic [0:0] s, input byte_t d);
    logic [8:0] obs;
    obs = 9'h1ff;
    if (idx < got.size()) obs = {got[idx].src, got[idx].data};
    checkOutput(tag, 32'(obs), 32'({s, d}));
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Match captured transfers against the per-source expected queues.
  task automatic processGot();
    xfer_t x;
    logic [31:0] exp;
    while (got.size() > 0) begin
      x = got.pop_front();
      outstanding[x.src] = outstanding[x.src] - 1;
      exp = 32'hdead;
      if (x.src == 1'b0 && expq0.size() > 0) exp = 32'(expq0.pop_front());
      if (x.src == 1'b1 && expq1.size() > 0) exp = 32'(expq1.pop_front());
      checkOutput("sb_data", 32'(x.data), exp);
    end
  endtask

  initial begin
    logic       hold;
    byte_t      pdata;
    logic [0:0] psrc;
    byte_t      seq;
    logic [1:0] pl;

    rst        = 1'b1;
    src_data   = '0;
    src_pulse  = '0;
    src_enable = 2'b11;
    ovf_clr    = '0;
    tx_ready   = 1'b0;
    seq        = 8'd0;
    outstanding[0] = 0;
    outstanding[1] = 0;
    @(posedge clk_i);
    #1;

    $display("[TB] reset with active strobes");
    for (int i = 0; i < 3; i++) begin
      src_pulse = 2'b11;
      src_data  = 16'h4130;
      step();
      checkOutput("rst_valid", 32'(tx_valid), 32'd0);
      checkOutput("rst_ovf", 32'(src_ovf), 32'd0);
    end
    src_pulse = 2'b00;
    rst = 1'b0;
    checkOutput("rst_data", 32'(tx_data), 32'd0);
    checkOutput("rst_src", 32'(tx_src), 32'd0);
    step();
    checkOutput("rst_nothing_queued", 32'(tx_valid), 32'd0);
    applyStimulus(2'b01, 8'h55, 8'h00);
    checkOutput("lat_n1_valid", 32'(tx_valid), 32'd0);
    step();
    checkOutput("lat_n2_valid", 32'(tx_valid), 32'd1);
    checkOutput("lat_n2_data", 32'(tx_data), 32'h55);
    checkOutput("lat_n2_src", 32'(tx_src), 32'd0);
    tx_ready = 1'b1;
    steps(2);
    checkOutput("lat_count", 32'(got.size()), 32'd1);
    checkOutput("lat_idle", 32'(tx_valid), 32'd0);
    got.delete();

    $display("[TB] ordering from one source");
    applyStimulus(2'b01, ASCII_0, 8'h00);
    applyStimulus(2'b01, ASCII_DASH, 8'h00);
    applyStimulus(2'b01, 8'd49, 8'h00);
    steps(5);
    checkOutput("ord_count", 32'(got.size()), 32'd3);
    checkXfer("ord_0", 0, 1'b0, 8'd48);
    checkXfer("ord_1", 1, 1'b0, 8'd45);
    checkXfer("ord_2", 2, 1'b0, 8'd49);
    got.delete();

    $display("[TB] simultaneous strobes");
    pulseReset();
    tx_ready = 1'b1;
    applyStimulus(2'b11, 8'h30, 8'h41);
    applyStimulus(2'b11, 8'h31, 8'h42);
    steps(6);
    checkOutput("sim_count", 32'(got.size()), 32'd4);
    checkXfer("sim_0", 0, 1'b0, 8'h30);
    checkXfer("sim_1", 1, 1'b1, 8'h41);
    checkXfer("sim_2", 2, 1'b0, 8'h31);
    checkXfer("sim_3", 3, 1'b1, 8'h42);
    got.delete();

    $display("[TB] overflow on source 1");
    pulseReset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b10, 8'h00, byte_t'(8'hA0 + i));
      checkOutput("ovf_flag_step", 32'(src_ovf), (i == 5) ? 32'd2 : 32'd0);
    end
    checkOutput("ovf_hold_valid", 32'(tx_valid), 32'd1);
    checkOutput("ovf_hold_data", 32'(tx_data), 32'hA0);
    checkOutput("ovf_hold_src", 32'(tx_src), 32'd1);
    tx_ready = 1'b1;
    steps(8);
    checkOutput("ovf_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) checkXfer("ovf_byte", i, 1'b1, byte_t'(8'hA0 + i));
    checkOutput("ovf_sticky", 32'(src_ovf), 32'd2);
    got.delete();
    ovf_clr = 2'b10;
    step();
    ovf_clr = 2'b00;
    checkOutput("ovf_cleared", 32'(src_ovf), 32'd0);

    $display("[TB] push into full FIFO with simultaneous pop");
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(2'b10, 8'h00, byte_t'(8'hB0 + i));
    tx_ready = 1'b1;
    applyStimulus(2'b10, 8'h00, 8'hB5);
    checkOutput("fullpop_ovf", 32'(src_ovf), 32'd0);
    steps(8);
    checkOutput("fullpop_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++) checkXfer("fullpop_byte", i, 1'b1, byte_t'(8'hB0 + i));
    got.delete();

    $display("[TB] random backpressure with two sources");
    pulseReset();
    for (int c = 0; c < 200; c++) begin
      tx_ready = 1'($urandom_range(0, 1));
      pl = 2'b00;
      src_data = '0;
      if (outstanding[0] < 4 && $urandom_range(0, 3) == 0) begin
        pl[0] = 1'b1;
        src_data[7:0] = seq;
        expq0.push_back(seq);
        outstanding[0] = outstanding[0] + 1;
        seq = seq + 8'd1;
      end
      if (outstanding[1] < 4 && $urandom_range(0, 3) == 0) begin
        pl[1] = 1'b1;
        src_data[15:8] = seq;
        expq1.push_back(seq);
        outstanding[1] = outstanding[1] + 1;
        seq = seq + 8'd1;
      end
      src_pulse = pl;
      hold  = tx_valid && !tx_ready;
      pdata = tx_data;
      psrc  = tx_src;
      step();
      src_pulse = 2'b00;
      if (hold) begin
        checkOutput("bp_valid_stable", 32'(tx_valid), 32'd1);
        checkOutput("bp_data_stable", 32'(tx_data), 32'(pdata));
        checkOutput("bp_src_stable", 32'(tx_src), 32'(psrc));
      end
      processGot();
    end
    tx_ready = 1'b1;
    steps(12);
    processGot();
    checkOutput("bp_q0_drained", 32'(expq0.size()), 32'd0);
    checkOutput("bp_q1_drained", 32'(expq1.size()), 32'd0);
    checkOutput("bp_ovf", 32'(src_ovf), 32'd0);
    checkOutput("bp_idle", 32'(tx_valid), 32'd0);

    $display("[TB] disable and reset mid-stream");
    tx_ready = 1'b0;
    applyStimulus(2'b01, 8'hD0, 8'h00);
    applyStimulus(2'b01, 8'hD1, 8'h00);
    src_enable = 2'b10;
    tx_ready = 1'b1;
    steps(5);
    checkOutput("dis_drain_count", 32'(got.size()), 32'd2);
    checkXfer("dis_drain_0", 0, 1'b0, 8'hD0);
    checkXfer("dis_drain_1", 1, 1'b0, 8'hD1);
    got.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(2'b01, byte_t'(8'hE0 + i), 8'h00);
    step();
    checkOutput("dis_no_valid", 32'(tx_valid), 32'd0);
    checkOutput("dis_no_ovf", 32'(src_ovf), 32'd0);
    src_enable = 2'b11;
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, byte_t'(8'hF0 + i), 8'h00);
    checkOutput("midrst_pre_valid", 32'(tx_valid), 32'd1);
    pulseReset();
    checkOutput("midrst_valid", 32'(tx_valid), 32'd0);
    checkOutput("midrst_data", 32'(tx_data), 32'd0);
    tx_ready = 1'b1;
    steps(4);
    checkOutput("midrst_count", 32'(got.size()), 32'd0);
    checkOutput("midrst_idle", 32'(tx_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
